txt_buf_uart_tx: RTL

Consumer of the hex-to-ASCII character stream (WEN / WR_ADDR / WR_TXT_DT).
- Stores incoming 7-bit characters in a 128-entry text buffer.
- On a START request, reads MSG_LEN characters starting at BASE_ADDR and sends them out as UART 8N1 frames on TXD.
- Sits between the character converter and the board-level serial pin. The host sees the 44-character read-back dump.

---
 rtl/txt_buf_pkg.sv | 19 +
 rtl/uart_tx_byte.sv | 52 +++++
 rtl/txt_buf_uart_tx.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/txt_buf_pkg.sv
// Shared types and constants for the text-buffer UART sender.
package txt_buf_pkg;
  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    FETCH,
    START_BIT,
    DATA,
    STOP,
    CR,
    LF,
    DONE_ST
  } state_t;

  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam int         BUF_DEPTH  = 128;
  localparam int         FRAME_BITS = 10;
endpackage

// File: rtl/uart_tx_byte.sv
// UART 8N1 byte serializer: baud counter, 10-bit frame shift register, ready/valid input.
module uart_tx_byte
  import txt_buf_pkg::*;
#(
  parameter int CLK_DIV = 434
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tick,
  output logic       txd
);
  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [3:0]  BIT_LAST = 4'(FRAME_BITS - 1);

  logic [15:0] baud_cnt;
  logic [9:0]  shreg;
  logic [3:0]  bit_cnt;
  logic        active;

  assign ready = !active;
  assign tick  = active && (baud_cnt == DIV_LAST);
  assign txd   = shreg[0];

  // Ones shift in behind the frame, so the line rests high once the stop bit is out.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      baud_cnt <= '0;
      shreg    <= '1;
      bit_cnt  <= '0;
      active   <= 1'b0;
    end else if (valid && ready) begin
      shreg    <= {1'b1, data, 1'b0};
      baud_cnt <= '0;
      bit_cnt  <= '0;
      active   <= 1'b1;
    end else if (tick) begin
      baud_cnt <= '0;
      shreg    <= {1'b1, shreg[9:1]};
      if (bit_cnt == BIT_LAST) begin
        bit_cnt <= '0;
        active  <= 1'b0;
      end else begin
        bit_cnt <= bit_cnt + 4'd1;
      end
    end else if (active) begin
      baud_cnt <= baud_cnt + 16'd1;
    end
  end
endmodule

// File: rtl/txt_buf_uart_tx.sv
// 128-entry text buffer that sends MSG_LEN characters as UART 8N1 frames on START.
// Define TXT_BUF_CRLF_EN to append a CR, LF trailer to every message.
module txt_buf_uart_tx
  import txt_buf_pkg::*;
#(
  parameter int CLK_DIV   = 434,
  parameter int MSG_LEN   = 44,
  parameter int BASE_ADDR = 0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       WEN,
  input  logic [6:0] WR_ADDR,
  input  logic [6:0] WR_TXT_DT,
  input  logic       START,
  output logic       BUSY,
  output logic       DONE,
  output logic       TXD
);
  localparam logic [7:0] LAST_CNT   = 8'(MSG_LEN);
  localparam logic [6:0] FIRST_ADDR = 7'(BASE_ADDR);

  logic [6:0] mem [BUF_DEPTH];
  logic [6:0] rd_data;
  logic [6:0] rd_ptr;
  logic [7:0] char_cnt;
  logic [2:0] bit_idx;
  state_t     state;
  logic       start_q, start_d, start_edge;
  logic [7:0] tx_byte;
  logic       tx_valid, tx_ready, tick;
`ifdef TXT_BUF_CRLF_EN
  logic [1:0] trail;
`endif

  // Read-before-write: a same-cycle write to rd_ptr is seen only by the next read.
  always_ff @(posedge CLK) begin
    if (WEN) mem[WR_ADDR] <= WR_TXT_DT;
    rd_data <= mem[rd_ptr];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      start_q <= 1'b0;
      start_d <= 1'b0;
    end else begin
      start_q <= START;
      start_d <= start_q;
    end
  end
  assign start_edge = start_q & ~start_d;

  always_comb begin
    tx_valid = (state == FETCH);
    tx_byte  = {1'b0, rd_data};
`ifdef TXT_BUF_CRLF_EN
    if (state == CR) begin
      tx_valid = 1'b1;
      tx_byte  = ASCII_CR;
    end else if (state == LF) begin
      tx_valid = 1'b1;
      tx_byte  = ASCII_LF;
    end
`endif
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      rd_ptr   <= '0;
      char_cnt <= '0;
      bit_idx  <= '0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
`ifdef TXT_BUF_CRLF_EN
      trail    <= '0;
`endif
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: if (start_edge) begin
          rd_ptr   <= FIRST_ADDR;
          char_cnt <= '0;
`ifdef TXT_BUF_CRLF_EN
          trail    <= '0;
`endif
          if (MSG_LEN == 0) begin
            state <= DONE_ST;
            DONE  <= 1'b1;
          end else begin
            state <= LOAD;
            BUSY  <= 1'b1;
          end
        end
        LOAD:  state <= FETCH;
        FETCH: if (tx_ready) state <= START_BIT;
        START_BIT: if (tick) begin
          bit_idx <= '0;
          state   <= DATA;
        end
        DATA: if (tick) begin
          if (bit_idx == 3'd7) state <= STOP;
          else bit_idx <= bit_idx + 3'd1;
        end
        STOP: if (tick) begin
`ifdef TXT_BUF_CRLF_EN
          if (trail == 2'd1) begin
            trail <= 2'd2;
            state <= LF;
          end else if (trail == 2'd2) begin
            state <= DONE_ST;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
          end else if (char_cnt + 8'd1 == LAST_CNT) begin
            char_cnt <= char_cnt + 8'd1;
            trail    <= 2'd1;
            state    <= CR;
          end else begin
            char_cnt <= char_cnt + 8'd1;
            rd_ptr   <= rd_ptr + 7'd1;
            state    <= LOAD;
          end
`else
          if (char_cnt + 8'd1 == LAST_CNT) begin
            char_cnt <= char_cnt + 8'd1;
            state    <= DONE_ST;
            BUSY     <= 1'b0;
            DONE     <= 1'b1;
          end else begin
            char_cnt <= char_cnt + 8'd1;
            rd_ptr   <= rd_ptr + 7'd1;
            state    <= LOAD;
          end
`endif
        end
`ifdef TXT_BUF_CRLF_EN
        CR: if (tx_ready) state <= START_BIT;
        LF: if (tx_ready) state <= START_BIT;
`endif
        DONE_ST: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  uart_tx_byte #(.CLK_DIV(CLK_DIV)) u_tx (
    .CLK   (CLK),
    .RST   (RST),
    .data  (tx_byte),
    .valid (tx_valid),
    .ready (tx_ready),
    .tick  (tick),
    .txd   (TXD)
  );
endmodule
